// File: rtl/pdp8_kw_pkg.sv
// Shared constants and types for the PDP-8 programmable clock.
// IOT function codes, CPU major states, sequencer and control layout.
package pdp8_kw_pkg;

    localparam logic [3:0] F0 = 4'd0;
    localparam logic [3:0] F1 = 4'd1;
    localparam logic [3:0] F2 = 4'd2;
    localparam logic [3:0] F3 = 4'd3;

    localparam logic [2:0] FN_NOP = 3'd0;
    localparam logic [2:0] CLEI   = 3'd1;
    localparam logic [2:0] CLDI   = 3'd2;
    localparam logic [2:0] CLSK   = 3'd3;
    localparam logic [2:0] CLLD   = 3'd4;
    localparam logic [2:0] CLAB   = 3'd5;
    localparam logic [2:0] CLRC   = 3'd6;
    localparam logic [2:0] CLCF   = 3'd7;

    localparam int CTL_RUN  = 0;
    localparam int CTL_MODE = 1;
    localparam int CTL_RATE = 2;

    typedef enum logic {
        SEQ_STOP = 1'b0,
        SEQ_RUN  = 1'b1
    } seq_t;

    typedef struct packed {
        logic       mode;
        logic [1:0] rate;
    } ctl_t;

endpackage

// File: rtl/pdp8_kw_if.sv
// IOT bus bundle between the CPU and the clock controller.
// The CPU side is master; the device side is slave.
interface pdp8_kw_if;

    logic        iot;
    logic [3:0]  state;
    logic [11:0] mb;
    logic [5:0]  io_select;
    logic [11:0] io_data_in;
    logic [11:0] io_data_out;
    logic        io_data_avail;
    logic        io_selected;
    logic        io_skip;
    logic        io_interrupt;

    modport master (
        output iot, state, mb, io_select, io_data_in,
        input  io_data_out, io_data_avail, io_selected,
        input  io_skip, io_interrupt
    );

    modport slave (
        input  iot, state, mb, io_select, io_data_in,
        output io_data_out, io_data_avail, io_selected,
        output io_skip, io_interrupt
    );

endinterface

// File: rtl/pdp8_kw_prescale.sv
// Rate-selectable tick divider; period is PRESCALE * 4^rate cycles.
// Runs on clock enables only; clr restarts the period and suppresses the tick.
module pdp8_kw_prescale #(
    parameter int PRESCALE = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       run,
    input  logic [1:0] rate,
    input  logic       clr,
    output logic       tick
);

    localparam int PW = $clog2(PRESCALE * 64);

    logic [PW-1:0] pre_q;
    logic [PW-1:0] term;
    logic [PW:0]   period;
    logic          at_term;

    always_comb begin
        period = (PW+1)'(PRESCALE) << {rate, 1'b0};
        term   = PW'(period - 1'b1);
    end

    assign at_term = (pre_q == term);
    assign tick    = run & at_term & ~clr;

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            pre_q <= '0;
        end else if (run) begin
            pre_q <= at_term ? '0 : pre_q + 1'b1;
        end
    end

endmodule

// File: rtl/pdp8_kw_ctl.sv
// PDP-8 programmable real-time clock: IOT decode, run/stop sequencer,
// 12-bit counter with free-run/reload, overflow flag, skip and interrupt.
module pdp8_kw_ctl
    import pdp8_kw_pkg::*;
#(
    parameter logic [5:0] DEVICE   = 6'o13,
    parameter int         PRESCALE = 16
) (
    input  logic        clk,
    input  logic        reset,
    pdp8_kw_if.slave    bus,
    output logic        tick
);

    logic        sel;
    logic [2:0]  fn;
    logic [11:0] din;
    logic        do_clei, do_cldi, do_clsk, do_clld;
    logic        do_clab, do_clrc, do_clcf;
    ctl_t        ctl_q;
    logic [11:0] buf_q;
    logic [11:0] cnt_q;
    logic        flag_q;
    logic        int_en_q;
    seq_t        seq_q, seq_d;
    logic        run;
    logic        ovf;
    logic        unused_mb;

    assign fn        = bus.mb[2:0];
    assign din       = bus.io_data_in;
    assign unused_mb = ^bus.mb[11:3];
    assign sel       = bus.iot
                     && (bus.state == F1)
                     && (bus.io_select == DEVICE);

    always_comb begin
        do_clei = 1'b0;
        do_cldi = 1'b0;
        do_clsk = 1'b0;
        do_clld = 1'b0;
        do_clab = 1'b0;
        do_clrc = 1'b0;
        do_clcf = 1'b0;
        if (sel) begin
            unique case (fn)
                CLEI:    do_clei = 1'b1;
                CLDI:    do_cldi = 1'b1;
                CLSK:    do_clsk = 1'b1;
                CLLD:    do_clld = 1'b1;
                CLAB:    do_clab = 1'b1;
                CLRC:    do_clrc = 1'b1;
                CLCF:    do_clcf = 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            seq_q <= SEQ_STOP;
        end else begin
            seq_q <= seq_d;
        end
    end

    // Only CLLD moves the sequencer; run follows the state directly.
    always_comb begin
        seq_d = seq_q;
        run   = 1'b0;
        unique case (seq_q)
            SEQ_STOP: begin
                if (do_clld && din[CTL_RUN]) seq_d = SEQ_RUN;
            end
            SEQ_RUN: begin
                run = 1'b1;
                if (do_clld && !din[CTL_RUN]) seq_d = SEQ_STOP;
            end
            default: seq_d = SEQ_STOP;
        endcase
    end

    pdp8_kw_prescale #(
        .PRESCALE (PRESCALE)
    ) u_prescale (
        .clk   (clk),
        .reset (reset),
        .run   (run),
        .rate  (ctl_q.rate),
        .clr   (do_clld | do_clab),
        .tick  (tick)
    );

    assign ovf = tick && (cnt_q == 12'o7777);

    always_ff @(posedge clk) begin
        if (reset) begin
            ctl_q    <= '0;
            buf_q    <= '0;
            cnt_q    <= '0;
            flag_q   <= 1'b0;
            int_en_q <= 1'b0;
        end else begin
            if (do_clld) begin
                ctl_q.mode <= din[CTL_MODE];
                ctl_q.rate <= din[CTL_RATE +: 2];
            end
            if (do_clei) begin
                int_en_q <= 1'b1;
            end else if (do_cldi) begin
                int_en_q <= 1'b0;
            end
            if (do_clab) begin
                buf_q <= din;
                cnt_q <= din;
            end else if (tick) begin
                cnt_q <= ovf ? (ctl_q.mode ? buf_q : 12'o0000)
                             : cnt_q + 12'd1;
            end
            // Overflow set wins over a same-cycle CLCF.
            if (ovf) begin
                flag_q <= 1'b1;
            end else if (do_clcf) begin
                flag_q <= 1'b0;
            end
        end
    end

    always_comb begin
        bus.io_selected   = sel;
        bus.io_skip       = do_clsk & flag_q;
        bus.io_data_avail = do_clrc;
        bus.io_data_out   = do_clrc ? cnt_q : 12'o0000;
        bus.io_interrupt  = int_en_q & flag_q;
    end

endmodule

// File: tb/tb_pdp8_kw_ctl.sv
// Bench for pdp8_kw_ctl: decode table, directed timing sequences and
// randomized IOT traffic against a cycle-level behavioural model.
module tb_pdp8_kw_ctl;
    import pdp8_kw_pkg::*;

    localparam int P = 4;

    logic clk = 1'b0;
    logic reset;
    logic tick;

    pdp8_kw_if bus ();

    pdp8_kw_ctl #(
        .DEVICE   (6'o13),
        .PRESCALE (P)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .tick  (tick)
    );

    always #5 clk = ~clk;

    int n_run  = 0;
    int n_fail = 0;

    int m_cnt, m_buf, m_rate, m_el;
    bit m_flag, m_ie, m_run, m_mode;
    bit m_valid = 1'b0;
    bit rst_v;

    logic        s_sel, s_skip, s_avail, s_int, s_tick;
    logic [11:0] s_out;

    typedef struct {
        logic        iot;
        logic [3:0]  st;
        logic [5:0]  sel;
        logic [2:0]  fn;
        logic [11:0] din;
        logic [14:0] exp;
        string       name;
    } vec_t;

    vec_t tbl[11];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0o want %0o", name, act, exp);
        end
    endtask

    // One clock cycle: drive, compare against the model, then advance it.
    task automatic step(input logic iot_v, input logic [3:0] st,
                        input logic [5:0] sel, input logic [2:0] fn,
                        input logic [11:0] din);
        bit          es, etick, ldc;
        int          per;
        logic [16:0] ev, av;
        @(negedge clk);
        reset          = rst_v;
        bus.iot        = iot_v;
        bus.state      = st;
        bus.io_select  = sel;
        bus.mb         = {3'o6, sel, fn};
        bus.io_data_in = din;
        #1;
        s_sel   = bus.io_selected;
        s_skip  = bus.io_skip;
        s_avail = bus.io_data_avail;
        s_out   = bus.io_data_out;
        s_int   = bus.io_interrupt;
        s_tick  = tick;
        es    = iot_v && (st == 4'd1) && (sel == 6'o13);
        ldc   = es && (fn == 3'd4 || fn == 3'd5);
        per   = P * (4 ** m_rate);
        etick = m_run && ((m_el + 1) % per == 0) && !ldc;
        ev = {es, es && fn == 3'd3 && m_flag, es && fn == 3'd6,
              (es && fn == 3'd6) ? 12'(m_cnt) : 12'd0,
              m_ie && m_flag, etick};
        av = {s_sel, s_skip, s_avail, s_out, s_int, s_tick};
        if (m_valid) chk("outs", 32'(av), 32'(ev));
        @(posedge clk);
        if (rst_v) begin
            m_cnt = 0; m_buf = 0; m_rate = 0; m_el = 0;
            m_flag = 0; m_ie = 0; m_run = 0; m_mode = 0;
            m_valid = 1'b1;
        end else begin
            if (es && fn == 3'd1) m_ie = 1;
            if (es && fn == 3'd2) m_ie = 0;
            if (es && fn == 3'd7) m_flag = 0;
            if (etick) begin
                if (m_cnt == 4095) begin
                    m_flag = 1;
                    m_cnt  = m_mode ? m_buf : 0;
                end else begin
                    m_cnt = m_cnt + 1;
                end
            end
            if (es && fn == 3'd5) begin
                m_buf = int'(din);
                m_cnt = int'(din);
                m_el  = 0;
            end else if (es && fn == 3'd4) begin
                m_run  = din[0];
                m_mode = din[1];
                m_rate = int'(din[3:2]);
                m_el   = 0;
            end else if (m_run) begin
                m_el = m_el + 1;
            end
        end
    endtask

    task automatic op(input logic [2:0] fn, input logic [11:0] din);
        step(1'b1, F1, 6'o13, fn, din);
    endtask

    task automatic idle();
        step(1'b0, F0, 6'o00, 3'd0, 12'o0000);
    endtask

    initial begin
        int nt;
        logic        r_iot;
        logic [3:0]  r_st;
        logic [5:0]  r_sel;
        logic [2:0]  r_fn;
        logic [11:0] r_din;

        tbl[0]  = '{1'b1, 4'd1, 6'o13, 3'd6, 12'o0000, {3'b101, 12'o1234}, "rd_f1"};
        tbl[1]  = '{1'b1, 4'd0, 6'o13, 3'd6, 12'o0000, {3'b000, 12'o0000}, "rd_f0"};
        tbl[2]  = '{1'b1, 4'd2, 6'o13, 3'd6, 12'o0000, {3'b000, 12'o0000}, "rd_f2"};
        tbl[3]  = '{1'b0, 4'd1, 6'o13, 3'd6, 12'o0000, {3'b000, 12'o0000}, "rd_noiot"};
        tbl[4]  = '{1'b1, 4'd1, 6'o12, 3'd6, 12'o0000, {3'b000, 12'o0000}, "rd_othdev"};
        tbl[5]  = '{1'b1, 4'd1, 6'o13, 3'd0, 12'o0000, {3'b100, 12'o0000}, "fn0"};
        tbl[6]  = '{1'b1, 4'd1, 6'o13, 3'd3, 12'o0000, {3'b100, 12'o0000}, "sk_noflag"};
        tbl[7]  = '{1'b1, 4'd3, 6'o13, 3'd5, 12'o7777, {3'b000, 12'o0000}, "ab_f3"};
        tbl[8]  = '{1'b1, 4'd1, 6'o13, 3'd6, 12'o0000, {3'b101, 12'o1234}, "rd_keep"};
        tbl[9]  = '{1'b0, 4'd1, 6'o13, 3'd5, 12'o0000, {3'b000, 12'o0000}, "ab_noiot"};
        tbl[10] = '{1'b1, 4'd1, 6'o13, 3'd6, 12'o0000, {3'b101, 12'o1234}, "rd_keep2"};

        rst_v = 1'b1;
        repeat (3) idle();
        rst_v = 1'b0;

        repeat (5) op(CLRC, 12'o0000);
        chk("rst_skip", s_skip, 0);
        chk("rst_out", s_out, 12'o0000);
        chk("rst_int", s_int, 0);
        op(CLSK, 12'o0000);
        chk("rst_clsk", s_skip, 0);

        op(CLAB, 12'o1234);
        foreach (tbl[i]) begin
            step(tbl[i].iot, tbl[i].st, tbl[i].sel, tbl[i].fn, tbl[i].din);
            chk(tbl[i].name, {s_sel, s_skip, s_avail, s_out}, tbl[i].exp);
        end

        op(CLAB, 12'o7775);
        op(CLLD, 12'o0001);
        for (int k = 1; k <= 12; k++) begin
            idle();
            chk("fr_tick", s_tick, (k % 4) == 0);
        end
        op(CLRC, 12'o0000);
        chk("fr_cnt", s_out, 12'o0000);
        op(CLSK, 12'o0000);
        chk("fr_skip", s_skip, 1);
        chk("fr_int0", s_int, 0);
        op(CLEI, 12'o0000);
        idle();
        chk("fr_int1", s_int, 1);

        op(CLAB, 12'o7776);
        op(CLLD, 12'o0007);
        for (int k = 1; k <= 32; k++) begin
            idle();
            chk("rl_tick", s_tick, (k % 16) == 0);
        end
        op(CLRC, 12'o0000);
        chk("rl_cnt", s_out, 12'o7776);

        op(CLCF, 12'o0000);
        op(CLSK, 12'o0000);
        chk("cf_clear", s_skip, 0);
        repeat (28) idle();
        op(CLCF, 12'o0000);
        chk("race_tick", s_tick, 1);
        op(CLSK, 12'o0000);
        chk("race_flag", s_skip, 1);
        op(CLCF, 12'o0000);
        op(CLSK, 12'o0000);
        chk("cf_alone", s_skip, 0);

        op(CLLD, 12'o0000);
        nt = 0;
        repeat (100) begin
            idle();
            if (s_tick === 1'b1) nt++;
        end
        chk("stop_ticks", nt, 0);
        op(CLRC, 12'o0000);
        chk("stop_cnt", s_out, 12'o7776);
        op(CLLD, 12'o0001);
        for (int k = 1; k <= 8; k++) begin
            idle();
            chk("restart_tick", s_tick, (k % 4) == 0);
        end
        op(CLEI, 12'o0000);
        idle();
        chk("pre_rst_int", s_int, 1);

        rst_v = 1'b1;
        idle();
        rst_v = 1'b0;
        idle();
        chk("mr_int", s_int, 0);
        op(CLRC, 12'o0000);
        chk("mr_cnt", s_out, 12'o0000);
        nt = 0;
        repeat (50) begin
            idle();
            if (s_tick !== 1'b0) nt++;
        end
        chk("mr_ticks", nt, 0);

        for (int i = 0; i < 1500; i++) begin
            rst_v = ($urandom_range(0, 199) == 0);
            r_iot = ($urandom_range(0, 2) == 0);
            r_st  = $urandom_range(0, 1) ? F1 : 4'($urandom_range(0, 3));
            r_sel = ($urandom_range(0, 7) == 0) ? 6'($urandom) : 6'o13;
            r_fn  = 3'($urandom);
            r_din = 12'($urandom);
            if (r_fn == CLLD) begin
                r_din[0]   = ($urandom_range(0, 3) != 0);
                r_din[3:2] = 2'($urandom_range(0, 1));
            end
            if (r_fn == CLAB && $urandom_range(0, 1) == 1) begin
                r_din = 12'o7770 + 12'($urandom_range(0, 7));
            end
            step(r_iot, r_st, r_sel, r_fn, r_din);
        end
        rst_v = 1'b0;
        idle();

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
